quick_spi_arbiter: RTL and testbench
====================================

Name: quick_spi_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one quick_spi master between NUM_REQ independent requesters.
- Accepts one queued transfer per requester through a valid/ready handshake and drives the master's start_transaction, slave, operation and outgoing_data.
- Waits for end_of_transaction, then returns incoming_data to the granted requester, tagged with its index.
- Sits between on-chip clients (sensor pollers, config engines) and the single quick_spi instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SLAVE_W, 2, width of the slave select index passed to quick_spi.
- WDATA_W, 16, width of outgoing_data.
- RDATA_W, 8, width of incoming_data.
- TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request; held until accepted.
- req_ready  out  NUM_REQ  one-hot acceptance pulse.
- req_slave  in  NUM_REQ*SLAVE_W  flattened slave index; requester i uses slice i.
- req_op  in  NUM_REQ  operation per requester (0 = write, 1 = read, quick_spi encoding).
- req_wdata  in  NUM_REQ*WDATA_W  flattened outgoing words.
- rsp_valid  out  1  single-cycle response strobe.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_rdata  out  RDATA_W  captured incoming_data.
- rsp_error  out  1  timeout flag, qualified by rsp_valid.
- spi_enable  out  1  to quick_spi enable.
- spi_start_transaction  out  1  to quick_spi start_transaction.
- spi_slave  out  SLAVE_W  to quick_spi slave.
- spi_operation  out  1  to quick_spi operation.
- spi_outgoing_data  out  WDATA_W  to quick_spi outgoing_data.
- spi_end_of_transaction  in  1  from quick_spi.
- spi_incoming_data  in  RDATA_W  from quick_spi.

Behaviour:
- Reset values (rst_n low at a clk edge): all outputs 0; state IDLE; rr_ptr = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer abandons the transfer with no response. The master is reset by the same rst_n.
- spi_enable goes to 1 on the first edge after reset and stays 1.
- FSM states: IDLE, BUSY, GAP. All outputs are registered.
- IDLE, any req_valid set:
  - Grant g = first set bit searching from rr_ptr+1 upward, with wrap-around.
  - Latch req_slave[g], req_op[g] and req_wdata[g] into the spi_* outputs.
  - Set req_ready[g] = 1 for exactly one cycle; rr_ptr <= g; spi_start_transaction <= 1; go to BUSY.
  - The handshake completes at the following edge, where valid and ready are both high. Requesters must hold their fields stable until then.
- IDLE, no req_valid: stay in IDLE; all req_ready = 0.
- BUSY:
  - spi_start_transaction and all spi_* fields are held constant.
  - On spi_end_of_transaction: spi_start_transaction <= 0; rsp_valid <= 1 for one cycle; rsp_id <= g; rsp_rdata <= spi_incoming_data (captured for writes too; clients ignore it); rsp_error <= 0; go to GAP.
- GAP: one idle cycle so the master returns to idle, then IDLE.
- Latency: request seen at edge N gives start_transaction high at N+1. Minimum spacing between consecutive starts is end_of_transaction + 2 cycles.
- spi_end_of_transaction outside BUSY is ignored.
- Simultaneous requests are served one per transfer in rotating order. No requester waits more than NUM_REQ-1 transfers.
- A requester dropping req_valid before acceptance simply loses its slot; no error.
- req_ready is never asserted outside the IDLE→BUSY transition.

Optional Feature:
- Macro: QUICK_SPI_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to BUSY and increments each BUSY cycle. If it reaches TIMEOUT_CYCLES without end_of_transaction:
  - spi_start_transaction <= 0; rsp_valid <= 1; rsp_error <= 1; rsp_rdata <= 0; go to GAP.
  - A late end_of_transaction is then ignored.
- Undefined: no counter, rsp_error tied to 0, BUSY waits indefinitely.

Decomposition:
- Package quick_spi_arb_pkg holds:
  - FSM state enum (IDLE, BUSY, GAP).
  - Operation constants OP_WRITE = 0, OP_READ = 1.
  - Default widths.
- Sub-module quick_spi_rr_picker: combinational round-robin priority search (req vector and rr_ptr in, grant index and any_grant out), reusable elsewhere.

Test Plan:
- Single write: requester 1 sends slave=2'b01, op=0, wdata=16'hCC82 → one req_ready[1] pulse; spi_start_transaction high until end_of_transaction; rsp_valid with rsp_id=1, rsp_error=0.
- Single read: requester 2, op=1, slave model returns 8'h95 → rsp_rdata=8'h95, rsp_id=2.
- All four requesters valid from reset → grant order 0,1,2,3, then 0 again if still valid; exactly one start per transfer; GAP cycle observed between transfers.
- Requester 3 continuously valid and requester 0 requesting after the first grant to 3 → 0 is served next, so requester 3 cannot starve requester 0.
- rst_n asserted during BUSY → next edge all outputs 0, no rsp_valid; after release requester 0 has priority.
- With QUICK_SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never ends the transaction → rsp_valid with rsp_error=1 exactly 16 cycles after entering BUSY; a later end_of_transaction pulse is ignored.

Source files
------------

// File: rtl/quick_spi_arb_pkg.sv
// quick_spi_arb_pkg: shared types and defaults for the quick_spi round-robin arbiter.
package quick_spi_arb_pkg;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_SLAVE_W        = 2;
    localparam int DEF_WDATA_W        = 16;
    localparam int DEF_RDATA_W        = 8;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;
    typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_e;
endpackage

// File: rtl/quick_spi_rr_picker.sv
// quick_spi_rr_picker: combinational round-robin search; first set bit above ptr_i, wrapping.
module quick_spi_rr_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic                       any_grant_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    logic [IDX_W-1:0] idx;
    // Scan from farthest to nearest so the nearest hit is the last assignment.
    always_comb begin
        grant_o = '0;
        idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (req_i[idx]) grant_o = idx;
        end
    end
    assign any_grant_o = |req_i;
endmodule

// File: rtl/quick_spi_arbiter.sv
// quick_spi_arbiter: round-robin sharing of one quick_spi master between NUM_REQ requesters.
// Optional watchdog on BUSY enabled by defining QUICK_SPI_ARB_TIMEOUT_EN.
module quick_spi_arbiter
    import quick_spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int SLAVE_W        = DEF_SLAVE_W,
    parameter int WDATA_W        = DEF_WDATA_W,
    parameter int RDATA_W        = DEF_RDATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*SLAVE_W-1:0]   req_slave,
    input  logic [NUM_REQ-1:0]           req_op,
    input  logic [NUM_REQ*WDATA_W-1:0]   req_wdata,
    output logic                         rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [RDATA_W-1:0]           rsp_rdata,
    output logic                         rsp_error,
    output logic                         spi_enable,
    output logic                         spi_start_transaction,
    output logic [SLAVE_W-1:0]           spi_slave,
    output logic                         spi_operation,
    output logic [WDATA_W-1:0]           spi_outgoing_data,
    input  logic                         spi_end_of_transaction,
    input  logic [RDATA_W-1:0]           spi_incoming_data
);
    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("quick_spi_arbiter: unsupported parameter values");
    end

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic                en_q, start_q, start_d;
    logic [SLAVE_W-1:0]  slave_q, slave_d;
    logic                op_q, op_d;
    logic [WDATA_W-1:0]  wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [RDATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [ID_W-1:0]     grant;
    logic                any_grant;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    quick_spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .any_grant_o (any_grant)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ready_d     = '0;
        start_d     = start_q;
        slave_d     = slave_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            IDLE: if (any_grant) begin
                state_d        = BUSY;
                ptr_d          = grant;
                ready_d[grant] = 1'b1;
                start_d        = 1'b1;
                slave_d        = req_slave[int'(grant)*SLAVE_W +: SLAVE_W];
                op_d           = req_op[grant];
                wdata_d        = req_wdata[int'(grant)*WDATA_W +: WDATA_W];
            end
            BUSY: begin
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (spi_end_of_transaction) begin
                    state_d     = GAP;
                    start_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = ptr_q;
                    rsp_rdata_d = spi_incoming_data;
                    rsp_error_d = 1'b0;
                end
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = GAP;
                    start_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = ptr_q;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                end
`endif
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            ready_q     <= '0;
            en_q        <= 1'b0;
            start_q     <= 1'b0;
            slave_q     <= '0;
            op_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            en_q        <= 1'b1;
            start_q     <= start_d;
            slave_q     <= slave_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
`ifdef QUICK_SPI_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign req_ready             = ready_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_id                = rsp_id_q;
    assign rsp_rdata             = rsp_rdata_q;
    assign rsp_error             = rsp_error_q;
    assign spi_enable            = en_q;
    assign spi_start_transaction = start_q;
    assign spi_slave             = slave_q;
    assign spi_operation         = op_q;
    assign spi_outgoing_data     = wdata_q;
endmodule

// File: tb/tb_quick_spi_arbiter.sv
// tb_quick_spi_arbiter: scoreboard bench for quick_spi_arbiter with a simple quick_spi slave model.
module tb_quick_spi_arbiter;
    localparam int N = 4, SW = 2, WW = 16, RW = 8, TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready, req_op;
    logic [N*SW-1:0] req_slave;
    logic [N*WW-1:0] req_wdata;
    logic            rsp_valid, rsp_error, spi_enable, spi_start_transaction, spi_operation;
    logic [1:0]      rsp_id;
    logic [RW-1:0]   rsp_rdata, spi_incoming_data;
    logic [SW-1:0]   spi_slave;
    logic [WW-1:0]   spi_outgoing_data;
    logic            spi_end_of_transaction;

    quick_spi_arbiter #(
        .NUM_REQ(N), .SLAVE_W(SW), .WDATA_W(WW), .RDATA_W(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_slave              (req_slave),
        .req_op                 (req_op),
        .req_wdata              (req_wdata),
        .rsp_valid              (rsp_valid),
        .rsp_id                 (rsp_id),
        .rsp_rdata              (rsp_rdata),
        .rsp_error              (rsp_error),
        .spi_enable             (spi_enable),
        .spi_start_transaction  (spi_start_transaction),
        .spi_slave              (spi_slave),
        .spi_operation          (spi_operation),
        .spi_outgoing_data      (spi_outgoing_data),
        .spi_end_of_transaction (spi_end_of_transaction),
        .spi_incoming_data      (spi_incoming_data)
    );

    typedef struct packed {logic [1:0] id; logic [SW-1:0] slave; logic op; logic [WW-1:0] wdata;} grant_t;
    typedef struct packed {logic [1:0] id; logic [RW-1:0] rdata; logic err;} rsp_t;
    grant_t gq[$];
    rsp_t   rq[$];
    int vectors = 0, errors = 0;
    int remaining[N];
    int cyc = 0, grant_cyc = 0, busy_cnt = 0;
    logic prev_rsp = 1'b0, slave_hang = 1'b0, late_pulse = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setup(input int i, input logic [SW-1:0] s, input logic op, input logic [WW-1:0] w, input int n);
        req_slave[i*SW +: SW] = s;
        req_op[i]             = op;
        req_wdata[i*WW +: WW] = w;
        remaining[i]          = n;
        req_valid[i]          = 1'b1;
    endtask

    task automatic exp_grant(input int i);
        gq.push_back({2'(i), req_slave[i*SW +: SW], req_op[i], req_wdata[i*WW +: WW]});
    endtask

    task automatic exp_rsp(input int i, input logic [RW-1:0] d, input logic e);
        rq.push_back({2'(i), d, e});
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400 && (gq.size() != 0 || rq.size() != 0); k++) @(negedge clk);
        if (gq.size() != 0 || rq.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain: %0d grants %0d responses outstanding, expected 0", gq.size(), rq.size());
            gq.delete();
            rq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 0);
        check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 0);
        check({tag, "_rsp_error"}, 32'(rsp_error), 0);
        check({tag, "_enable"}, 32'(spi_enable), 0);
        check({tag, "_start"}, 32'(spi_start_transaction), 0);
        check({tag, "_slave"}, 32'(spi_slave), 0);
        check({tag, "_op"}, 32'(spi_operation), 0);
        check({tag, "_wdata"}, 32'(spi_outgoing_data), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Slave model: ends each transaction three cycles after start, returning the high data byte.
    initial begin
        spi_end_of_transaction = 1'b0;
        spi_incoming_data = '0;
        forever begin
            @(negedge clk);
            spi_end_of_transaction = 1'b0;
            if (!spi_start_transaction) busy_cnt = 0;
            else if (!slave_hang) begin
                busy_cnt++;
                if (busy_cnt == 3) begin
                    spi_end_of_transaction = 1'b1;
                    spi_incoming_data = spi_outgoing_data[15:8];
                end
            end
            if (late_pulse) begin
                spi_end_of_transaction = 1'b1;
                late_pulse = 1'b0;
            end
        end
    end

    // Requesters drop valid after the handshake edge once their transfer count is used up.
    initial begin
        logic [N-1:0] rs;
        forever begin
            @(negedge clk);
            rs = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (rs[i] && req_valid[i]) begin
                    remaining[i]--;
                    if (remaining[i] <= 0) req_valid[i] = 1'b0;
                end
        end
    end

    initial begin
        grant_t g;
        rsp_t   r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_ready != '0) begin
                    if (gq.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_grant: got ready %b expected none", req_ready);
                    end else begin
                        g = gq.pop_front();
                        check("grant_onehot", 32'(req_ready), 32'(1) << g.id);
                        check("grant_start", 32'(spi_start_transaction), 1);
                        check("grant_slave", 32'(spi_slave), 32'(g.slave));
                        check("grant_op", 32'(spi_operation), 32'(g.op));
                        check("grant_wdata", 32'(spi_outgoing_data), 32'(g.wdata));
                        check("grant_gap", 32'(prev_rsp), 0);
                        grant_cyc = cyc;
                    end
                end
                if (rsp_valid) begin
                    if (rq.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_rsp: got id %0d expected no response", rsp_id);
                    end else begin
                        r = rq.pop_front();
                        check("rsp_id", 32'(rsp_id), 32'(r.id));
                        check("rsp_rdata", 32'(rsp_rdata), 32'(r.rdata));
                        check("rsp_error", 32'(rsp_error), 32'(r.err));
                        check("rsp_start_low", 32'(spi_start_transaction), 0);
                        if (r.err) check("timeout_latency", 32'(cyc - grant_cyc), 32'(TO));
                    end
                end
            end
            prev_rsp = rsp_valid;
            cyc++;
        end
    end

    initial begin
        req_valid = '0;
        req_op    = '0;
        req_slave = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("enable", 32'(spi_enable), 1);

        setup(1, 2'b01, 1'b0, 16'hCC82, 1);
        exp_grant(1);
        exp_rsp(1, 8'hCC, 1'b0);
        wait_done();

        setup(2, 2'b10, 1'b1, 16'h9500, 1);
        exp_grant(2);
        exp_rsp(2, 8'h95, 1'b0);
        wait_done();

        do_reset();
        setup(0, 2'd0, 1'b0, 16'h1111, 2);
        setup(1, 2'd1, 1'b1, 16'h2222, 1);
        setup(2, 2'd2, 1'b0, 16'h3333, 1);
        setup(3, 2'd3, 1'b1, 16'h4444, 1);
        for (int i = 0; i < N; i++) exp_grant(i);
        exp_grant(0);
        exp_rsp(0, 8'h11, 1'b0);
        exp_rsp(1, 8'h22, 1'b0);
        exp_rsp(2, 8'h33, 1'b0);
        exp_rsp(3, 8'h44, 1'b0);
        exp_rsp(0, 8'h11, 1'b0);
        wait_done();

        slave_hang = 1'b1;
        setup(1, 2'd3, 1'b1, 16'hABCD, 1);
        exp_grant(1);
        for (int k = 0; k < 20 && !spi_start_transaction; k++) @(negedge clk);
        check("hang_started", 32'(spi_start_transaction), 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("busy_reset");
        rst_n = 1'b1;
        slave_hang = 1'b0;
        setup(2, 2'd1, 1'b0, 16'h6622, 1);
        setup(0, 2'd2, 1'b1, 16'h3300, 1);
        exp_grant(0);
        exp_grant(2);
        exp_rsp(0, 8'h33, 1'b0);
        exp_rsp(2, 8'h66, 1'b0);
        wait_done();

        do_reset();
        setup(3, 2'd1, 1'b0, 16'h7700, 2);
        exp_grant(3);
        for (int k = 0; k < 20 && !spi_start_transaction; k++) @(negedge clk);
        setup(0, 2'd2, 1'b1, 16'h5A00, 1);
        exp_grant(0);
        exp_grant(3);
        exp_rsp(3, 8'h77, 1'b0);
        exp_rsp(0, 8'h5A, 1'b0);
        exp_rsp(3, 8'h77, 1'b0);
        wait_done();

`ifdef QUICK_SPI_ARB_TIMEOUT_EN
        slave_hang = 1'b1;
        setup(2, 2'd1, 1'b1, 16'hEE00, 1);
        exp_grant(2);
        exp_rsp(2, 8'h00, 1'b1);
        wait_done();
        late_pulse = 1'b1;
        repeat (5) @(negedge clk);
        slave_hang = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
